// File: rtl/input_io_ctrl.sv
// Input MMIO controller: synchronizes switches and button, debounces the button, serves CPU input reads.
// Latency: non-blocking read acks 1 cycle after the request; blocking read acks 1 cycle after a new press.
// Backpressure: stall holds the CPU combinationally while rd_req is high and no ack is being presented.
//
// Ports:
//   clk, rst        - single clock, asynchronous active-high reset
//   Switches[7:0]   - raw switch pins (asynchronous)
//   Button          - raw push-button pin (asynchronous, bouncy)
//   rd_req          - CPU load to the input address, held until rd_ack
//   rd_blocking     - 1: wait for a new press, 0: return switches now
//   rd_data         - last captured switches, zero-extended
//   rd_ack          - one-cycle completion pulse
//   stall           - CPU pipeline hold
//   btn_level       - debounced button level
module input_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        Switches,
  input  logic              Button,
  input  logic              rd_req,
  input  logic              rd_blocking,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ack,
  output logic              stall,
  output logic              btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  // The differing sample that arrives while cnt holds this value is the one
  // that completes the stable run, so the level flips on that edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    ACK
  } state_t;

  logic [7:0]       sw_s1, sw_s2;
  logic             btn_s1, btn_s2;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic [7:0]       cap;
  logic             ack_q;
  logic             cap_en;
  state_t           state, state_nxt;

  // Two-flop synchronizers; nothing downstream looks at the raw pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= Switches;
      sw_s2  <= sw_s1;
      btn_s1 <= Button;
      btn_s2 <= btn_s1;
    end
  end

  // Debouncer: any sample that matches the current level restarts the run,
  // so a glitch shorter than DEBOUNCE_CYCLES never reaches btn_level.
  // press rises together with a 0->1 change of btn_level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      btn_level <= 1'b0;
      press     <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_level <= ~btn_level;
        press     <= ~btn_level;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Read FSM. A press seen outside WAIT_PRESS is simply dropped: presses
  // are never buffered, so only a press after arming can satisfy a read.
  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          if (rd_blocking) begin
            state_nxt = WAIT_PRESS;
          end else begin
            cap_en    = 1'b1;
            state_nxt = ACK;
          end
        end
      end
      WAIT_PRESS: begin
        // Abort takes priority over a coincident press.
        if (!rd_req) begin
          state_nxt = IDLE;
        end else if (press) begin
          cap_en    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cap   <= '0;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= (state_nxt == ACK);
      if (cap_en) begin
        cap <= sw_s2;
      end
    end
  end

  assign rd_data = DATA_W'(cap);
  assign rd_ack  = ack_q;
  // Combinational so the CPU holds on the very cycle the request appears.
  assign stall   = rd_req & (state != ACK) & ~rst;

endmodule

// File: tb/tb_input_io_ctrl.sv
// Testbench for input_io_ctrl: directed stimulus, per-cycle comparison against a behavioural model.
// Latency: model tracks the 2-edge synchronizer delay and debounce run explicitly.
// Backpressure: stall is checked against the model on every non-reset cycle.
module tb_input_io_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  Switches;
  logic        Button;
  logic        rd_req;
  logic        rd_blocking;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        stall;
  logic        btn_level;

  int tests  = 0;
  int errors = 0;
  bit chk_en = 0;

  input_io_ctrl #(.DEBOUNCE_CYCLES(DB), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .Switches   (Switches),
    .Button     (Button),
    .rd_req     (rd_req),
    .rd_blocking(rd_blocking),
    .rd_data    (rd_data),
    .rd_ack     (rd_ack),
    .stall      (stall),
    .btn_level  (btn_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Synchronized values are the pin values seen two edges earlier. The
  // debounced level flips once DB consecutive synchronized samples have all
  // disagreed with it. A read is either pending-for-press or answered.
  logic [7:0] sp1, sp2, m_data;
  logic       bp1, bp2;
  logic       m_level, m_press, m_armed, m_ack;
  bit         run[$];

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        sp1 = '0; sp2 = '0; bp1 = 0; bp2 = 0;
        m_level = 0; m_press = 0; m_armed = 0; m_ack = 0; m_data = '0;
        run.delete();
      end else begin
        logic [7:0] s_sync;
        logic       b_sync;
        logic       press_seen;
        s_sync     = sp2;
        b_sync     = bp2;
        press_seen = m_press;

        if (m_ack) begin
          m_ack = 0;
        end else if (m_armed) begin
          if (!rd_req) begin
            m_armed = 0;
          end else if (press_seen) begin
            m_data  = s_sync;
            m_armed = 0;
            m_ack   = 1;
          end
        end else if (rd_req) begin
          if (rd_blocking) m_armed = 1;
          else begin
            m_data = s_sync;
            m_ack  = 1;
          end
        end

        m_press = 0;
        if (b_sync == m_level) begin
          run.delete();
        end else begin
          run.push_back(b_sync);
          if (run.size() == DB) begin
            m_level = ~m_level;
            m_press = m_level;
            run.delete();
          end
        end

        sp2 = sp1; sp1 = Switches;
        bp2 = bp1; bp1 = Button;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_ack = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        chk("cyc_rd_ack",    {31'b0, rd_ack},    {31'b0, m_ack});
        chk("cyc_rd_data",   rd_data,            {24'b0, m_data});
        chk("cyc_stall",     {31'b0, stall},     {31'b0, rd_req & ~m_ack});
        chk("cyc_btn_level", {31'b0, btn_level}, {31'b0, m_level});
        chk("cyc_ack_twice", {31'b0, prev_ack & rd_ack}, 32'h0);
        prev_ack = rd_ack;
      end else begin
        prev_ack = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1; Switches = 8'h00; Button = 0; rd_req = 1; rd_blocking = 0;
    #1;
    chk("rst_rd_ack",    {31'b0, rd_ack},    32'h0);
    chk("rst_rd_data",   rd_data,            32'h0);
    chk("rst_stall",     {31'b0, stall},     32'h0);
    chk("rst_btn_level", {31'b0, btn_level}, 32'h0);
    tick(3);
    rd_req = 0; rst = 0; chk_en = 1;
    tick(1);
    chk("post_rst_ack", {31'b0, rd_ack}, 32'h0);

    // Non-blocking read
    Switches = 8'b0000_0010;
    tick(3);
    rd_req = 1; rd_blocking = 0;
    #1 chk("nb_stall_req", {31'b0, stall}, 32'h1);
    tick(1);
    chk("nb_ack",   {31'b0, rd_ack}, 32'h1);
    chk("nb_data",  rd_data,         32'h0000_0002);
    chk("nb_stall", {31'b0, stall},  32'h0);
    rd_req = 0;
    tick(1);
    chk("nb_ack_end", {31'b0, rd_ack}, 32'h0);

    // Glitch: 3-cycle pulse
    Button = 1;
    tick(3);
    Button = 0;
    tick(10);
    chk("glitch_level", {31'b0, btn_level}, 32'h0);

    // Debounce accept: 50 ns high / 50 ns low
    for (int p = 0; p < 3; p++) begin
      Button = 1;
      tick(5);
      chk("db_edge5", {31'b0, btn_level}, 32'h0);
      Button = 0;
      tick(1);
      chk("db_edge6", {31'b0, btn_level}, 32'h1);
      tick(4);
    end
    tick(8);

    // Blocking read with a clean press
    Switches = 8'h00;
    rd_req = 1; rd_blocking = 1;
    #1 chk("blk_stall_arm", {31'b0, stall}, 32'h1);
    tick(3);
    Switches = 8'hA5;
    tick(3);
    Button = 1;
    tick(6);
    chk("blk_no_ack_yet", {31'b0, rd_ack}, 32'h0);
    chk("blk_stall_wait", {31'b0, stall},  32'h1);
    tick(1);
    chk("blk_ack",  {31'b0, rd_ack}, 32'h1);
    chk("blk_data", rd_data,         32'h0000_00A5);
    rd_req = 0;
    tick(2);
    Button = 0;
    tick(8);

    // Press coincident with arming must not count
    Button = 1;
    tick(6);
    rd_req = 1; rd_blocking = 1;
    tick(10);
    chk("coinc_still_stalled", {31'b0, stall}, 32'h1);
    Switches = 8'h3C;
    tick(3);
    rd_req = 0;
    tick(1);
    chk("abort_ack",  {31'b0, rd_ack}, 32'h0);
    chk("abort_data", rd_data,         32'h0000_00A5);
    Button = 0;
    tick(8);

    // Abort coincident with a press
    rd_req = 1; rd_blocking = 1;
    tick(2);
    Button = 1;
    tick(6);
    rd_req = 0;
    tick(1);
    chk("abort_press_ack",  {31'b0, rd_ack}, 32'h0);
    chk("abort_press_data", rd_data,         32'h0000_00A5);
    tick(1);
    chk("abort_press_ack2", {31'b0, rd_ack}, 32'h0);
    Button = 0;
    tick(8);

    // Press with no request does nothing
    Button = 1;
    tick(10);
    chk("idle_press_level", {31'b0, btn_level}, 32'h1);
    chk("idle_press_data",  rd_data,            32'h0000_00A5);

    // Reset while in WAIT_PRESS, asserted away from any clock edge
    rd_req = 1; rd_blocking = 1;
    tick(2);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_ack",   {31'b0, rd_ack},    32'h0);
    chk("mid_rst_data",  rd_data,            32'h0);
    chk("mid_rst_stall", {31'b0, stall},     32'h0);
    chk("mid_rst_level", {31'b0, btn_level}, 32'h0);
    Button = 0; rd_req = 0;
    tick(2);
    rst = 0;
    tick(1);
    chk("after_rst_ack", {31'b0, rd_ack}, 32'h0);
    tick(5);

    // Read still works after reset
    Switches = 8'h81;
    tick(3);
    rd_req = 1; rd_blocking = 0;
    tick(1);
    chk("final_ack",  {31'b0, rd_ack}, 32'h1);
    chk("final_data", rd_data,         32'h0000_0081);
    rd_req = 0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/input_io_ctrl.md
# input_io_ctrl

Memory-mapped input controller between the board's raw switch/button pins and the mini RISC-V CPU's load path. It synchronizes and debounces the button, synchronizes the 8 switches, and serves CPU input reads. Non-blocking reads return the switches immediately; blocking reads stall the CPU until a new button press. It sits beside the data-memory MMIO decode inside `main` and drives the CPU's stall input.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button level change. Must be ≥1. Simulation uses 4; the board build uses a larger value.
- `DATA_W`, default 32: width of `rd_data`.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `Switches` in 8: raw switch pins, asynchronous to `clk`.
- `Button` in 1: raw push-button pin, asynchronous and bouncy.
- `rd_req` in 1: CPU load to the input MMIO address. Held high until `rd_ack`.
- `rd_blocking` in 1: qualifies `rd_req`. 1 = wait for a press; 0 = return switches now. Stable while `rd_req` is high.
- `rd_data` out DATA_W: captured switches, zero-extended.
- `rd_ack` out 1: one-cycle completion pulse.
- `stall` out 1: CPU pipeline hold.
- `btn_level` out 1: debounced button level.

## Operation
- **Synchronizers.** `Button` and all 8 `Switches` bits each pass through a 2-flop synchronizer. Only the synchronized values are used downstream.
- **Debouncer.**
  - Counter `cnt` has width clog2(DEBOUNCE_CYCLES)+1.
  - Each cycle the synchronized button equals `btn_level`: `cnt` clears to 0.
  - Each cycle it differs: `cnt` increments.
  - When a differing sample would bring `cnt` to DEBOUNCE_CYCLES, `btn_level` toggles on that edge and `cnt` clears.
  - The counter never wraps.
- **Press event.** `press` is a one-cycle internal pulse, registered on the same edge as the 0→1 transition of `btn_level`. A 1→0 transition produces no event.
- **FSM states:** IDLE, WAIT_PRESS, ACK.
  - IDLE, `rd_req` & !`rd_blocking`: capture synchronized switches into `rd_data` and go to ACK.
  - IDLE, `rd_req` & `rd_blocking`: go to WAIT_PRESS (armed).
  - IDLE, `press`: the event is discarded. Presses are never buffered, and a press coincident with arming does not count.
  - WAIT_PRESS, `press`: capture switches (synchronized value on that cycle) and go to ACK.
  - WAIT_PRESS, !`rd_req`: abort to IDLE with no ack and `rd_data` unchanged. Abort wins over a simultaneous `press`.
  - ACK: `rd_ack`=1, then go to IDLE unconditionally. A `press` during ACK is discarded.
- **Back-to-back reads.** The CPU drops or re-issues `rd_req` after `rd_ack`. If `rd_req` is high in the IDLE cycle after ACK, it is a new request.
- **Outputs.**
  - `rd_data[7:0]` holds the last capture; bits above 7 are 0. It is held until the next capture.
  - `rd_ack` is registered and equals (state==ACK).
  - `stall` = `rd_req` & (state != ACK) & !`rst`. It is combinational, so the CPU holds on the same cycle the request appears.

## Timing
- **Reset.** On `rst` high, asynchronously and immediately:
  - state = IDLE.
  - `rd_data`=0, `rd_ack`=0, `btn_level`=0, `cnt`=0, `press`=0.
  - Synchronizer flops = 0.
  - `stall`=0 while `rst` is high.
- **Reset mid-operation.** `rst` during WAIT_PRESS or ACK drops any pending read with no ack.
- **Button latency.** A raw `Button` change, once stable, reaches `btn_level` on edge 2+DEBOUNCE_CYCLES after the first edge that samples it.
- **Glitch rejection.** A synchronized pulse shorter than DEBOUNCE_CYCLES cycles never changes `btn_level`.
- **Non-blocking read.** `rd_req` is sampled in IDLE at edge n; `rd_ack` is high in cycle n+1. `stall` is high for exactly 1 cycle.
- **Blocking read.** `press` is high at edge m while in WAIT_PRESS; `rd_ack` is high in cycle m+1.
- **Ack frequency.** At most one `rd_ack` per request. `rd_ack` is never high for two consecutive cycles.
- **Switch skew.** Switch changes appear in captured data 2 edges after the raw change.

## Test plan
- **Reset.** Assert `rst` at an arbitrary time (e.g. 17 ns into a 10 ns clock) while in WAIT_PRESS -> all outputs 0 immediately; after release, state IDLE and no spurious `rd_ack`.
- **Debounce accept.** DEBOUNCE_CYCLES=4, `Button` high 50 ns / low 50 ns repeating -> `btn_level` rises 6 edges after each rising edge of `Button`; one `press` per period.
- **Glitch.** 3-cycle `Button` high pulse -> `btn_level` stays 0 and no `press`.
- **Non-blocking read.** `Switches`=8'b0000_0010, `rd_req`=1, `rd_blocking`=0 -> `rd_ack` next cycle, `rd_data`=32'h0000_0002, `stall` high 1 cycle.
- **Blocking read.** Blocking read issued, then `Switches`=8'hA5 and a clean press -> `stall` high throughout; `rd_ack` the cycle after `press`; `rd_data`=32'h0000_00A5. A press already in progress at arming produces no ack.
- **Abort.** Drop `rd_req` in WAIT_PRESS (with and without a coincident `press`) -> IDLE, no `rd_ack`, `rd_data` unchanged. A later press with no request produces nothing.
